// File: rtl/hrange_accum_pkg.sv
// Shared types for the hrange/hrange_accum generator pair: data width default,
// FSM state encodings and the generic valid/ready/done handshake bundle.
package hrange_accum_pkg;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, RUN, SUMMARY, DONE_PULSE} state_t;

  typedef enum logic {HR_IDLE, HR_RUN} hr_state_t;

  typedef struct packed {
    logic valid;
    logic ready;
    logic done;
  } gen_ctl_t;
endpackage

// File: rtl/hrange_accum_if.sv
// Caller-facing generator port of hrange_accum: start/arguments in, tuple stream out.
interface hrange_accum_if
  import hrange_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);
  logic                    _start;
  logic signed [WIDTH-1:0] base;
  logic signed [WIDTH-1:0] limit;
  logic signed [WIDTH-1:0] step;
  logic                    _ready;
  logic                    _valid;
  logic                    _done;
  logic signed [WIDTH-1:0] _0;
  logic signed [WIDTH-1:0] _1;

  modport master (
    output _start, base, limit, step, _ready,
    input  _valid, _done, _0, _1
  );

  modport slave (
    input  _start, base, limit, step, _ready,
    output _valid, _done, _0, _1
  );
endinterface

// File: rtl/hrange_accum_hrange.sv
// Inner generator: yields base, base+step, ... while inside the range (Python range
// semantics, step 0 yields nothing), then pulses done for one cycle.
module hrange
  import hrange_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    ready,
  output logic                    valid,
  output logic                    done,
  output logic signed [WIDTH-1:0] value
);
  hr_state_t state, next_state;

  // One extra bit keeps cur+step from wrapping back into the range.
  logic signed [WIDTH:0] cur_p0;
  logic signed [WIDTH:0] lim_p0;
  logic signed [WIDTH:0] stp_p0;
  logic                  in_range;

  always_comb begin
    in_range = 1'b0;
    if (stp_p0 != '0) begin
      if (!stp_p0[WIDTH]) in_range = (cur_p0 < lim_p0);
      else                in_range = (cur_p0 > lim_p0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= HR_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    valid      = 1'b0;
    done       = 1'b0;
    if (start) begin
      next_state = HR_RUN;
    end else if (state == HR_RUN) begin
      valid = in_range;
      done  = !in_range;
      if (!in_range) next_state = HR_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      cur_p0 <= {base[WIDTH-1], base};
      lim_p0 <= {limit[WIDTH-1], limit};
      stp_p0 <= {step[WIDTH-1], step};
    end else if (valid && ready) begin
      cur_p0 <= cur_p0 + stp_p0;
    end
  end

  assign value = cur_p0[WIDTH-1:0];
endmodule

// File: rtl/hrange_accum.sv
// Accumulating generator over hrange: emits (i, running_total) per element,
// then (count, total), then a one-cycle done pulse.
module hrange_accum
  import hrange_accum_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           _clock,
  input  logic           _reset,
  hrange_accum_if.slave  io
);
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1);

  state_t                  state, next_state;
  gen_ctl_t                inner_ctl;
  logic signed [WIDTH-1:0] inner_value;

  logic signed [WIDTH-1:0] total;
  logic signed [WIDTH-1:0] count;
  logic                    done_seen;
  logic                    vld_p0;
  logic signed [WIDTH-1:0] out0_p0;
  logic signed [WIDTH-1:0] out1_p0;

  logic out_xfer;
  logic inner_xfer;
  logic load_item;
  logic load_sum;

  hrange #(.WIDTH(WIDTH)) u_hrange (
    .clk   (_clock),
    .rst   (_reset),
    .start (io._start),
    .base  (io.base),
    .limit (io.limit),
    .step  (io.step),
    .ready (inner_ctl.ready),
    .valid (inner_ctl.valid),
    .done  (inner_ctl.done),
    .value (inner_value)
  );

  // No skid buffer: the inner stream only advances when the output slot frees.
  assign inner_ctl.ready = !vld_p0 || io._ready;
  assign inner_xfer      = inner_ctl.valid && inner_ctl.ready;
  assign out_xfer        = vld_p0 && io._ready;

  always_comb begin
    next_state = state;
    load_item  = 1'b0;
    load_sum   = 1'b0;
    if (io._start) begin
      next_state = RUN;
    end else begin
      unique case (state)
        IDLE: next_state = IDLE;
        RUN: begin
          if (inner_xfer) begin
            load_item = 1'b1;
          end else if (done_seen && (!vld_p0 || out_xfer)) begin
            load_sum   = 1'b1;
            next_state = SUMMARY;
          end
        end
        SUMMARY:    if (out_xfer) next_state = DONE_PULSE;
        DONE_PULSE: next_state = IDLE;
        default:    next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state     <= IDLE;
      total     <= '0;
      count     <= '0;
      done_seen <= 1'b0;
      vld_p0    <= 1'b0;
      out0_p0   <= '0;
      out1_p0   <= '0;
    end else begin
      state <= next_state;
      if (io._start) begin
        total     <= '0;
        count     <= '0;
        done_seen <= 1'b0;
        vld_p0    <= 1'b0;
      end else begin
        // The inner done pulse is latched so a stalled output cannot drop it.
        if (state == RUN && inner_ctl.done) done_seen <= 1'b1;
        if (load_item) begin
          total   <= total + inner_value;
          count   <= count + ONE;
          out0_p0 <= inner_value;
          out1_p0 <= total + inner_value;
          vld_p0  <= 1'b1;
        end else if (load_sum) begin
          out0_p0 <= count;
          out1_p0 <= total;
          vld_p0  <= 1'b1;
        end else if (out_xfer) begin
          vld_p0  <= 1'b0;
        end
      end
    end
  end

  assign io._valid = vld_p0;
  assign io._done  = (state == DONE_PULSE);
  assign io._0     = out0_p0;
  assign io._1     = out1_p0;
endmodule

// File: tb/tb_hrange_accum.sv
// Directed bench for hrange_accum: element/summary tuples, stalls, aborts and reset.
module tb_hrange_accum;
  logic clk = 1'b0;
  logic rst = 1'b1;

  hrange_accum_if #(.WIDTH(32)) bus ();

  hrange_accum #(.WIDTH(32)) dut (
    ._clock (clk),
    ._reset (rst),
    .io     (bus)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  logic signed [31:0] g0 [16];
  logic signed [31:0] g1 [16];
  int                 gc [16];
  int ngot, ndone, done_gap, stall_err, last_xfer;

  initial begin
    #400000;
    $display("FAIL watchdog expired (time %0t, want finish earlier)", $time);
    $fatal(1);
  end

  task automatic start_run(input int b, input int l, input int s);
    @(negedge clk);
    bus._start = 1'b1;
    bus.base   = b;
    bus.limit  = l;
    bus.step   = s;
    @(posedge clk);
    #1 bus._start = 1'b0;
  endtask

  // mode 0: ready=1; mode 1: ready 1,0,0,1 repeating; mode 2: hold ready=0 on the (3,x) tuple for 6 cycles
  task automatic collect(input int mode, input int max_tuples, input int budget);
    int hold = 0;
    int done_cyc = -1;
    logic prev_stall = 1'b0;
    logic signed [31:0] h0 = 0;
    logic signed [31:0] h1 = 0;
    logic r;
    ngot = 0; ndone = 0; done_gap = -1; stall_err = 0; last_xfer = -100;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (bus._done === 1'b1) begin
        ndone++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          done_gap = cyc - last_xfer;
        end
      end
      if (prev_stall && (bus._valid !== 1'b1 || bus._0 !== h0 || bus._1 !== h1)) stall_err++;
      case (mode)
        1: r = (cyc % 4 == 0) || (cyc % 4 == 3);
        2: begin
          r = !(bus._valid === 1'b1 && bus._0 == 3 && hold < 6);
          if (!r) hold++;
        end
        default: r = 1'b1;
      endcase
      bus._ready = r;
      if (bus._valid === 1'b1 && r) begin
        if (ngot < 16) begin
          g0[ngot] = bus._0;
          g1[ngot] = bus._1;
          gc[ngot] = cyc;
        end
        ngot++;
        last_xfer = cyc;
      end
      prev_stall = (bus._valid === 1'b1) && !r;
      h0 = bus._0;
      h1 = bus._1;
      if (max_tuples > 0 && ngot >= max_tuples) break;
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
  endtask

  task automatic test_reset();
    bus._start = 1'b0; bus.base = 0; bus.limit = 0; bus.step = 0; bus._ready = 1'b0;
    rst = 1'b1;
    #12;
    tests++; if (bus._valid !== 1'b0) begin failed++; $display("FAIL reset_valid got %b want 0", bus._valid); end
    tests++; if (bus._done !== 1'b0) begin failed++; $display("FAIL reset_done got %b want 0", bus._done); end
    tests++; if (bus._0 !== 32'sd0) begin failed++; $display("FAIL reset_0 got %0d want 0", bus._0); end
    tests++; if (bus._1 !== 32'sd0) begin failed++; $display("FAIL reset_1 got %0d want 0", bus._1); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int e0 [6] = '{0, 2, 4, 6, 8, 5};
    int e1 [6] = '{0, 2, 6, 12, 20, 20};
    start_run(0, 10, 2);
    collect(0, 0, 100);
    tests++; if (ngot !== 6) begin failed++; $display("FAIL basic_count got %0d want 6", ngot); end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (g0[k] !== e0[k] || g1[k] !== e1[k]) begin
        failed++;
        $display("FAIL basic_tuple%0d got (%0d,%0d) want (%0d,%0d)", k, g0[k], g1[k], e0[k], e1[k]);
      end
    end
    tests++; if (gc[4] - gc[0] !== 4) begin failed++; $display("FAIL basic_back_to_back got span %0d want 4", gc[4] - gc[0]); end
    tests++; if (ndone !== 1) begin failed++; $display("FAIL basic_done_pulses got %0d want 1", ndone); end
    tests++; if (done_gap !== 1) begin failed++; $display("FAIL basic_done_gap got %0d want 1", done_gap); end
  endtask

  task automatic test_empty();
    start_run(5, 5, 1);
    collect(0, 0, 50);
    tests++; if (ngot !== 1) begin failed++; $display("FAIL empty_count got %0d want 1", ngot); end
    tests++;
    if (g0[0] !== 32'sd0 || g1[0] !== 32'sd0) begin
      failed++; $display("FAIL empty_summary got (%0d,%0d) want (0,0)", g0[0], g1[0]);
    end
    tests++; if (ndone !== 1) begin failed++; $display("FAIL empty_done_pulses got %0d want 1", ndone); end
    tests++; if (done_gap !== 1) begin failed++; $display("FAIL empty_done_gap got %0d want 1", done_gap); end
  endtask

  task automatic test_backpressure();
    int e0 [6] = '{0, 2, 4, 6, 8, 5};
    int e1 [6] = '{0, 2, 6, 12, 20, 20};
    start_run(0, 10, 2);
    collect(1, 0, 200);
    tests++; if (ngot !== 6) begin failed++; $display("FAIL bp_count got %0d want 6", ngot); end
    for (int k = 0; k < 6; k++) begin
      tests++;
      if (g0[k] !== e0[k] || g1[k] !== e1[k]) begin
        failed++;
        $display("FAIL bp_tuple%0d got (%0d,%0d) want (%0d,%0d)", k, g0[k], g1[k], e0[k], e1[k]);
      end
    end
    tests++; if (stall_err !== 0) begin failed++; $display("FAIL bp_stable got %0d changes want 0", stall_err); end
    tests++; if (ndone !== 1) begin failed++; $display("FAIL bp_done_pulses got %0d want 1", ndone); end
  endtask

  task automatic test_stall_at_done();
    int e0 [4] = '{1, 2, 3, 3};
    int e1 [4] = '{1, 3, 6, 6};
    start_run(1, 4, 1);
    collect(2, 0, 100);
    tests++; if (ngot !== 4) begin failed++; $display("FAIL stall_count got %0d want 4", ngot); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (g0[k] !== e0[k] || g1[k] !== e1[k]) begin
        failed++;
        $display("FAIL stall_tuple%0d got (%0d,%0d) want (%0d,%0d)", k, g0[k], g1[k], e0[k], e1[k]);
      end
    end
    tests++; if (stall_err !== 0) begin failed++; $display("FAIL stall_stable got %0d changes want 0", stall_err); end
    tests++; if (ndone !== 1) begin failed++; $display("FAIL stall_done_pulses got %0d want 1", ndone); end
    tests++; if (done_gap !== 1) begin failed++; $display("FAIL stall_done_gap got %0d want 1", done_gap); end
  endtask

  task automatic test_reset_midstream();
    int e0 [4] = '{0, 1, 2, 3};
    int e1 [4] = '{0, 1, 3, 3};
    start_run(0, 100, 1);
    collect(0, 3, 50);
    tests++; if (ngot !== 3) begin failed++; $display("FAIL rstmid_pre_count got %0d want 3", ngot); end
    @(posedge clk);
    #1;
    tests++; if (bus._valid !== 1'b1) begin failed++; $display("FAIL rstmid_pre_valid got %b want 1", bus._valid); end
    #1 rst = 1'b1;
    #1;
    tests++; if (bus._valid !== 1'b0) begin failed++; $display("FAIL rstmid_valid got %b want 0", bus._valid); end
    tests++; if (bus._done !== 1'b0) begin failed++; $display("FAIL rstmid_done got %b want 0", bus._done); end
    @(negedge clk);
    rst = 1'b0;
    start_run(0, 3, 1);
    collect(0, 0, 60);
    tests++; if (ngot !== 4) begin failed++; $display("FAIL rstmid_count got %0d want 4", ngot); end
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (g0[k] !== e0[k] || g1[k] !== e1[k]) begin
        failed++;
        $display("FAIL rstmid_tuple%0d got (%0d,%0d) want (%0d,%0d)", k, g0[k], g1[k], e0[k], e1[k]);
      end
    end
    tests++; if (ndone !== 1) begin failed++; $display("FAIL rstmid_done_pulses got %0d want 1", ndone); end
  endtask

  task automatic test_restart();
    int e0 [3] = '{10, 11, 2};
    int e1 [3] = '{10, 21, 21};
    start_run(0, 100, 1);
    collect(0, 2, 50);
    tests++; if (ngot !== 2) begin failed++; $display("FAIL restart_pre_count got %0d want 2", ngot); end
    start_run(10, 12, 1);
    collect(0, 0, 60);
    tests++; if (ngot !== 3) begin failed++; $display("FAIL restart_count got %0d want 3", ngot); end
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (g0[k] !== e0[k] || g1[k] !== e1[k]) begin
        failed++;
        $display("FAIL restart_tuple%0d got (%0d,%0d) want (%0d,%0d)", k, g0[k], g1[k], e0[k], e1[k]);
      end
    end
    tests++; if (ndone !== 1) begin failed++; $display("FAIL restart_done_pulses got %0d want 1", ndone); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_stall_at_done();
    test_reset_midstream();
    test_restart();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
